sys_time_sync: RTL and testbench
================================

Name: sys_time_sync

Overview:
- Sits directly downstream of the controller.
- Consumes the controller's ECAT_SYNC_TIME (ns, 64-bit) and its SYNC_SET pulse, plus the EtherCAT SYNC0 pin.
- Converts the sync time from nanoseconds to 20.48 MHz clock ticks using an iterative divider.
- Loads a free-running 64-bit system-time counter on the next SYNC0 edge. The resulting SYS_TIME is the common timebase for the modulation, STM and silencer stages.

Parameters:
- SYNC_LATENCY, 3: ticks added to the converted time to compensate for SYNC0 synchronizer and edge-detect latency.
- DIVISOR, 3125: ns-to-tick denominator. One tick = 3125/64 ns at 20.48 MHz.

Ports:
- CLK  in  1  20.48 MHz system clock.
- RST_N  in  1  asynchronous active-low reset.
- ECAT_SYNC_TIME  in  64  absolute time (ns) of the next SYNC0 event; valid when SYNC_SET=1.
- SYNC_SET  in  1  single-cycle request to resynchronize.
- ECAT_SYNC  in  1  raw SYNC0 from the ESC; asynchronous to CLK.
- SYS_TIME  out  64  system time in ticks.
- SYNCED  out  1  high once the first load has happened.
- BUSY  out  1  high while in DIV or ARMED.

Behaviour:
- Reset (RST_N=0, async):
  - SYS_TIME=0, SYNCED=0, BUSY=0, state=IDLE.
  - Synchronizer flops, divider registers and the armed value are cleared.
- SYS_TIME increments by 1 every CLK in all states, including before SYNCED. It wraps 2^64-1 -> 0 with no flag.
- SYNC0 path:
  - 2-flop synchronizer, then an edge register.
  - sync_rise = s2 & ~s3.
  - Total latency from pin edge to sync_rise is SYNC_LATENCY cycles (3).
- Conversion: target = floor({ECAT_SYNC_TIME,6'b0} / DIVISOR).
  - Restoring divider: 70-bit dividend, 13-bit remainder, one quotient bit per cycle, exactly 70 cycles.
  - Quotient is truncated to 64 bits, which is lossless since 2^70/3125 < 2^59.
- State IDLE: on SYNC_SET, capture ECAT_SYNC_TIME, clear the divider, go to DIV, BUSY=1 from the next cycle.
- State DIV:
  - Iterate for 70 cycles, then latch load_val = quotient + SYNC_LATENCY and go to ARMED.
  - sync_rise while in DIV is ignored (not queued).
- State ARMED: on sync_rise, SYS_TIME <= load_val (instead of the increment), SYNCED <= 1, go to IDLE, BUSY=0 on the next cycle.
- SYNC_SET while in DIV or ARMED: recapture and restart DIV from iteration 0. Latest request wins; any previous load_val is discarded.
- SYNC_SET and sync_rise in the same cycle while ARMED: SYNC_SET wins. No load happens; restart DIV.
- SYNCED stays at 1 until reset; later resyncs do not clear it.
- Asserting RST_N mid-DIV or mid-ARMED aborts immediately with the reset values above.
- No handshake back to the controller. SYNC_SET is a fire-and-forget pulse; BUSY is for status only.

Test Plan:
- Reset: hold RST_N=0 for 5 cycles, release -> SYS_TIME=0, SYNCED=0, BUSY=0, and SYS_TIME reads 10 after 10 further cycles.
- Basic sync: ECAT_SYNC_TIME=3125 with SYNC_SET pulse, wait 80 cycles, raise ECAT_SYNC -> SYS_TIME=67 on the sync_rise cycle, 68 on the next cycle, SYNCED=1, BUSY=0.
- Real value: ECAT_SYNC_TIME=1_000_000 -> load_val=20483. Then 100 random 64-bit times -> loaded SYS_TIME == floor(t*64/3125)+3 for each, checked against a bench model.
- Early edge: ECAT_SYNC pulse 10 cycles after SYNC_SET (during DIV) -> no load and SYNCED stays 0. A second pulse at 100 cycles -> load happens.
- Restart: SYNC_SET(t=3125), then SYNC_SET(t=6250) 30 cycles later, then ECAT_SYNC 100 cycles after that -> SYS_TIME=131 (128+3), not 67.
- Collision and mid-op reset: SYNC_SET coincident with sync_rise in ARMED -> no load, BUSY stays 1. Reset asserted in ARMED -> BUSY=0, SYNCED=0, SYS_TIME=0, and a following ECAT_SYNC edge does not load.

Source files
------------

// File: rtl/sys_time_sync.sv
// sys_time_sync: free-running 64-bit system time in 20.48 MHz ticks.
// Converts the controller's next-SYNC0 time from ns to ticks and loads the
// counter with that value (plus synchronizer latency) on the next SYNC0 edge.
//
// Ports:
//   CLK            20.48 MHz system clock
//   RST_N          asynchronous active-low reset
//   ECAT_SYNC_TIME absolute ns time of the next SYNC0 event, valid with SYNC_SET
//   SYNC_SET       single-cycle resynchronization request
//   ECAT_SYNC      raw SYNC0 pin from the ESC, asynchronous to CLK
//   SYS_TIME       system time in ticks
//   SYNCED         high once the first load has happened
//   BUSY           high while converting or armed
module sys_time_sync #(
  parameter int unsigned SYNC_LATENCY = 3,
  parameter int unsigned DIVISOR      = 3125
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] ECAT_SYNC_TIME,
  input  logic        SYNC_SET,
  input  logic        ECAT_SYNC,
  output logic [63:0] SYS_TIME,
  output logic        SYNCED,
  output logic        BUSY
);

  localparam int unsigned TIME_W     = 64;
  localparam int unsigned DIVIDEND_W = 70;
  localparam int unsigned REM_W      = 13;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned LAST_ITER  = DIVIDEND_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  sync_s1, sync_s2, sync_s3;
  logic                  sync_rise;

  logic [DIVIDEND_W-1:0] dividend;
  logic [REM_W-1:0]      rem;
  logic [TIME_W-1:0]     quo;
  logic [CNT_W-1:0]      iter_cnt;
  logic [TIME_W-1:0]     load_val;

  logic [REM_W:0]        trial;
  logic                  q_bit;
  logic [REM_W-1:0]      rem_nxt;
  logic [TIME_W-1:0]     quo_nxt;
  logic                  last_iter;

  logic                  div_start;
  logic                  div_step;
  logic                  load_latch;
  logic                  time_load;

  // SYNC0 synchronizer plus edge register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_s1 <= 1'b0;
      sync_s2 <= 1'b0;
      sync_s3 <= 1'b0;
    end else begin
      sync_s1 <= ECAT_SYNC;
      sync_s2 <= sync_s1;
      sync_s3 <= sync_s2;
    end
  end

  assign sync_rise = sync_s2 & ~sync_s3;

  // One restoring-division step: shift in the next dividend bit and subtract if it fits
  always_comb begin
    trial     = {rem, dividend[DIVIDEND_W-1]};
    q_bit     = (trial >= (REM_W+1)'(DIVISOR));
    rem_nxt   = q_bit ? REM_W'(trial - (REM_W+1)'(DIVISOR)) : REM_W'(trial);
    // Quotient upper bits are always zero, so truncating to 64 bits is lossless
    quo_nxt   = TIME_W'({quo, q_bit});
    last_iter = (iter_cnt == CNT_W'(LAST_ITER));
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a new request always restarts the conversion
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (SYNC_SET) state_nxt = ST_DIV;
      end
      ST_DIV: begin
        if (SYNC_SET)       state_nxt = ST_DIV;
        else if (last_iter) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (SYNC_SET)       state_nxt = ST_DIV;
        else if (sync_rise) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control strobes; SYNC_SET takes priority over iteration and loading
  always_comb begin
    div_start  = 1'b0;
    div_step   = 1'b0;
    load_latch = 1'b0;
    time_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        div_start = SYNC_SET;
      end
      ST_DIV: begin
        div_start  = SYNC_SET;
        div_step   = ~SYNC_SET;
        load_latch = ~SYNC_SET & last_iter;
      end
      ST_ARMED: begin
        div_start = SYNC_SET;
        time_load = ~SYNC_SET & sync_rise;
      end
      default: ;
    endcase
  end

  // Divider datapath and armed load value
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dividend <= '0;
      rem      <= '0;
      quo      <= '0;
      iter_cnt <= '0;
      load_val <= '0;
    end else begin
      if (div_start) begin
        dividend <= {ECAT_SYNC_TIME, 6'b0};
        rem      <= '0;
        quo      <= '0;
        iter_cnt <= '0;
      end else if (div_step) begin
        dividend <= {dividend[DIVIDEND_W-2:0], 1'b0};
        rem      <= rem_nxt;
        quo      <= quo_nxt;
        iter_cnt <= iter_cnt + CNT_W'(1);
      end
      if (load_latch) begin
        load_val <= quo_nxt + TIME_W'(SYNC_LATENCY);
      end
    end
  end

  // System time counter and status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SYS_TIME <= '0;
      SYNCED   <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      SYS_TIME <= time_load ? load_val : SYS_TIME + TIME_W'(1);
      SYNCED   <= SYNCED | time_load;
      BUSY     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sys_time_sync.sv
`timescale 1ns/1ps
module tb_sys_time_sync;

  logic        CLK;
  logic        RST_N;
  logic [63:0] ECAT_SYNC_TIME;
  logic        SYNC_SET;
  logic        ECAT_SYNC;
  logic [63:0] SYS_TIME;
  logic        SYNCED;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] prev_time;
  logic        prev_valid = 1'b0;

  sys_time_sync dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .ECAT_SYNC_TIME (ECAT_SYNC_TIME),
    .SYNC_SET       (SYNC_SET),
    .ECAT_SYNC      (ECAT_SYNC),
    .SYS_TIME       (SYS_TIME),
    .SYNCED         (SYNCED),
    .BUSY           (BUSY)
  );

  initial CLK = 1'b0;
  always #24.414 CLK = ~CLK;

  // Reference conversion: floor(t*64/3125) + 3 in wide arithmetic
  function automatic logic [63:0] model_load(input logic [63:0] t);
    logic [127:0] wide;
    wide = ({64'd0, t} * 128'd64) / 128'd3125;
    return 64'(wide) + 64'd3;
  endfunction

  // Monitor: any break in the +1 sequence is a load; compare it with the scoreboard
  always @(negedge CLK) begin
    logic [63:0] e;
    if (!RST_N) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && (SYS_TIME != prev_time + 64'd1)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: SYS_TIME=%0d after %0d, no load expected", SYS_TIME, prev_time);
        end else begin
          e = exp_q.pop_front();
          if (SYS_TIME !== e) begin
            errors++;
            $display("FAIL load_value: SYS_TIME=%0d expected %0d", SYS_TIME, e);
          end
        end
      end
      prev_time  = SYS_TIME;
      prev_valid = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1
  task automatic do_sync_set(input logic [63:0] t);
    ECAT_SYNC_TIME = t;
    SYNC_SET       = 1'b1;
    @(posedge CLK); #1;
    SYNC_SET       = 1'b0;
  endtask

  task automatic sync_pulse(input bit expect_load, input logic [63:0] val);
    if (expect_load) exp_q.push_back(val);
    ECAT_SYNC = 1'b1;
    repeat (4) @(posedge CLK);
    #1 ECAT_SYNC = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [63:0] t;
    RST_N          = 1'b0;
    ECAT_SYNC_TIME = '0;
    SYNC_SET       = 1'b0;
    ECAT_SYNC      = 1'b0;

    // Reset: 5 cycles low, then free-running count
    repeat (5) @(posedge CLK);
    #1 RST_N = 1'b1;
    #1;
    check("reset_sys_time", SYS_TIME, 64'd0);
    check("reset_synced", 64'(SYNCED), 64'd0);
    check("reset_busy", 64'(BUSY), 64'd0);
    repeat (10) @(posedge CLK);
    #1;
    check("count_after_10", SYS_TIME, 64'd10);

    // Early edge during DIV is ignored; a later edge loads 1_000_000 ns -> 20483
    do_sync_set(64'd1_000_000);
    check("busy_in_div", 64'(BUSY), 64'd1);
    repeat (9) @(posedge CLK); #1;
    sync_pulse(1'b0, 64'd0);
    check("early_edge_synced", 64'(SYNCED), 64'd0);
    repeat (73) @(posedge CLK); #1;
    check("armed_busy", 64'(BUSY), 64'd1);
    sync_pulse(1'b1, 64'd20483);
    check("real_synced", 64'(SYNCED), 64'd1);

    // Basic: 3125 ns -> 64 ticks + 3
    do_sync_set(64'd3125);
    repeat (80) @(posedge CLK); #1;
    sync_pulse(1'b1, 64'd67);
    check("basic_synced", 64'(SYNCED), 64'd1);
    check("basic_busy", 64'(BUSY), 64'd0);

    // Largest input value
    do_sync_set(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (75) @(posedge CLK); #1;
    sync_pulse(1'b1, 64'd377789318629571617 + 64'd3);

    // Random times against the wide-arithmetic model
    for (int i = 0; i < 100; i++) begin
      t = {$urandom, $urandom};
      do_sync_set(t);
      repeat (75) @(posedge CLK); #1;
      sync_pulse(1'b1, model_load(t));
    end

    // Restart: the later request wins
    do_sync_set(64'd3125);
    repeat (29) @(posedge CLK); #1;
    do_sync_set(64'd6250);
    repeat (99) @(posedge CLK); #1;
    sync_pulse(1'b1, 64'd131);

    // Collision: SYNC_SET on the same cycle sync_rise is sampled in ARMED
    do_sync_set(64'd6250);
    repeat (80) @(posedge CLK); #1;
    ECAT_SYNC = 1'b1;
    repeat (2) @(posedge CLK); #1;
    do_sync_set(64'd6250);
    repeat (2) @(posedge CLK); #1;
    check("collision_busy", 64'(BUSY), 64'd1);
    check("collision_synced", 64'(SYNCED), 64'd1);
    repeat (80) @(posedge CLK); #1;
    ECAT_SYNC = 1'b0;
    repeat (4) @(posedge CLK); #1;
    check("rearmed_busy", 64'(BUSY), 64'd1);

    // Reset while ARMED aborts everything
    RST_N = 1'b0;
    #1;
    check("midreset_sys_time", SYS_TIME, 64'd0);
    check("midreset_synced", 64'(SYNCED), 64'd0);
    check("midreset_busy", 64'(BUSY), 64'd0);
    repeat (3) @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK); #1;
    sync_pulse(1'b0, 64'd0);
    check("post_reset_synced", 64'(SYNCED), 64'd0);
    check("post_reset_busy", 64'(BUSY), 64'd0);

    repeat (5) @(posedge CLK); #1;
    check("pending_loads", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
